// File: rtl/i2c_target_tx_if.sv
// i2c_target_tx_if: bus pins and local transmit handshake of the I2C read target
interface i2c_target_tx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       byte_done;
  logic       master_nack;
  logic       underrun;
  modport slave (
    input  scl_in, sda_in, tx_data, tx_valid,
    output sda_oe, tx_ready, busy, byte_done, master_nack, underrun
  );
  modport master (
    output scl_in, sda_in, tx_data, tx_valid,
    input  sda_oe, tx_ready, busy, byte_done, master_nack, underrun
  );
endinterface

// File: rtl/i2c_target_tx.sv
// i2c_target_tx: I2C target answering master reads from a one-entry holding buffer
module i2c_target_tx #(
  parameter logic [6:0] DEV_ADDR      = 7'h50,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input logic clk,
  input logic rstn,
  i2c_target_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, TX, MACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] cnt, cnt_n;
  logic [7:0] addr_sr, addr_n, shift, shift_n, buf_q, ld_byte;
  logic oe, oe_n, busy_q, busy_n, full, load, accept;
  logic done_q, done_n, nack_q, nack_n, und_q, und_n;
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign accept    = bus.tx_valid & ~full;
  assign ld_byte   = full ? buf_q : UNDERRUN_BYTE;
  assign bus.sda_oe      = oe;
  assign bus.tx_ready    = ~full;
  assign bus.busy        = busy_q;
  assign bus.byte_done   = done_q;
  assign bus.master_nack = nack_q;
  assign bus.underrun    = und_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_sr;
    shift_n = shift;
    oe_n    = oe;
    busy_n  = busy_q;
    done_n  = 1'b0;
    nack_n  = 1'b0;
    und_n   = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: oe_n = 1'b0;
      ADDR: begin
        if (scl_rise) begin
          addr_n = {addr_sr[6:0], sda_s};
          cnt_n  = cnt + 4'd1;
        end
        if (scl_fall && cnt == 4'd8) begin
          state_n = (addr_sr[7:1] == DEV_ADDR && addr_sr[0]) ? ACK_ADDR : WAIT_STOP;
          oe_n    = addr_sr[7:1] == DEV_ADDR && addr_sr[0];
          busy_n  = addr_sr[7:1] == DEV_ADDR && addr_sr[0];
        end
      end
      ACK_ADDR: load = scl_fall;
      TX: if (scl_fall) begin
        if (cnt == 4'd7) begin
          oe_n    = 1'b0;
          state_n = MACK;
        end else begin
          shift_n = {shift[6:0], 1'b0};
          oe_n    = ~shift[6];
          cnt_n   = cnt + 4'd1;
        end
      end
      MACK: begin
        if (scl_rise) begin
          done_n  = 1'b1;
          nack_n  = sda_s;
          busy_n  = ~sda_s;
          state_n = sda_s ? WAIT_STOP : MACK;
          cnt_n   = 4'd8;
        end
        load = scl_fall && cnt == 4'd8;
      end
      WAIT_STOP: oe_n = 1'b0;
      default: state_n = IDLE;
    endcase
    // Loading a byte puts its MSB on the bus in the same cycle
    if (load) begin
      shift_n = ld_byte;
      und_n   = ~full;
      oe_n    = ~ld_byte[7];
      cnt_n   = 4'd0;
      state_n = TX;
    end
    if (stop_det || start_det) begin
      state_n = stop_det ? IDLE : ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_sr  <= 8'd0;
      shift    <= 8'd0;
      oe       <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      und_q    <= 1'b0;
      full     <= 1'b0;
      buf_q    <= 8'd0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      state    <= state_n;
      cnt      <= cnt_n;
      addr_sr  <= addr_n;
      shift    <= shift_n;
      oe       <= oe_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      nack_q   <= nack_n;
      und_q    <= und_n;
      full     <= (full & ~load) | accept;
      buf_q    <= accept ? bus.tx_data : buf_q;
    end
  end
endmodule

// File: tb/tb_i2c_target_tx.sv
// tb_i2c_target_tx: directed bit-banged I2C master reads against the target
module tb_i2c_target_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic bus_sda;
  int n_chk = 0, n_fail = 0;
  int bd_cnt = 0, mn_cnt = 0, ur_cnt = 0, busy_cyc = 0, oe_cyc = 0;
  i2c_target_tx_if bus();
  i2c_target_tx #(.DEV_ADDR(7'h50), .SYNC_STAGES(2), .UNDERRUN_BYTE(8'hFF)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus_sda    = sda_m & ~bus.sda_oe;
  assign bus.sda_in = bus_sda;
  assign bus.scl_in = scl;
  always @(posedge clk) begin
    if (bus.byte_done) bd_cnt++;
    if (bus.master_nack) mn_cnt++;
    if (bus.underrun) ur_cnt++;
    if (bus.busy) busy_cyc++;
    if (bus.sda_oe) oe_cyc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_io(input logic b, output logic s);
    sda_m = b;
    wait_n(4);
    scl = 1'b1;
    wait_n(4);
    s = bus_sda;
    wait_n(4);
    scl = 1'b0;
    wait_n(4);
  endtask
  task automatic start_cond();
    sda_m = 1'b1;
    wait_n(4);
    scl = 1'b1;
    wait_n(8);
    sda_m = 1'b0;
    wait_n(8);
    scl = 1'b0;
    wait_n(4);
  endtask
  task automatic stop_cond();
    sda_m = 1'b0;
    wait_n(4);
    scl = 1'b1;
    wait_n(8);
    sda_m = 1'b1;
    wait_n(8);
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, ack);
  endtask
  task automatic read_byte(input logic m_nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(m_nack, s);
  endtask
  task automatic push(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  initial begin
    logic ack, s;
    logic [7:0] d;
    logic [3:0] nib;
    int bd0, mn0, ur0, busy0, oe0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    wait_n(3);
    check("rst_oe", bus.sda_oe, 0);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.byte_done, bus.master_nack, bus.underrun}, 0);
    rstn = 1'b1;
    wait_n(4);
    // single byte read, master NACK
    push(8'hA5);
    check("t1_ready_full", bus.tx_ready, 0);
    bd0 = bd_cnt; mn0 = mn_cnt; ur0 = ur_cnt;
    start_cond();
    send_byte(8'hA1, ack);
    check("t1_addr_ack", ack, 0);
    check("t1_busy", bus.busy, 1);
    check("t1_ready_loaded", bus.tx_ready, 1);
    read_byte(1'b1, d);
    check("t1_byte", d, 8'hA5);
    check("t1_byte_done", bd_cnt - bd0, 1);
    check("t1_nack", mn_cnt - mn0, 1);
    check("t1_underrun", ur_cnt - ur0, 0);
    check("t1_busy_off", bus.busy, 0);
    stop_cond();
    check("t1_idle_oe", bus.sda_oe, 0);
    // wrong address and write direction are both NACKed
    busy0 = busy_cyc; oe0 = oe_cyc;
    start_cond();
    send_byte(8'hA3, ack);
    check("t2_addr51_nack", ack, 1);
    stop_cond();
    start_cond();
    send_byte(8'hA0, ack);
    check("t2_write_nack", ack, 1);
    stop_cond();
    check("t2_oe_cycles", oe_cyc - oe0, 0);
    check("t2_busy_cycles", busy_cyc - busy0, 0);
    // two-byte read with refill
    push(8'h3C);
    bd0 = bd_cnt; mn0 = mn_cnt; ur0 = ur_cnt;
    start_cond();
    send_byte(8'hA1, ack);
    check("t3_addr_ack", ack, 0);
    check("t3_ready_after_load", bus.tx_ready, 1);
    push(8'hC3);
    check("t3_ready_refilled", bus.tx_ready, 0);
    read_byte(1'b0, d);
    check("t3_byte0", d, 8'h3C);
    check("t3_ready_second_load", bus.tx_ready, 1);
    check("t3_busy_mid", bus.busy, 1);
    read_byte(1'b1, d);
    check("t3_byte1", d, 8'hC3);
    check("t3_byte_done", bd_cnt - bd0, 2);
    check("t3_nack", mn_cnt - mn0, 1);
    check("t3_underrun", ur_cnt - ur0, 0);
    stop_cond();
    // empty buffer underrun
    ur0 = ur_cnt;
    start_cond();
    send_byte(8'hA1, ack);
    check("t4_addr_ack", ack, 0);
    check("t4_underrun", ur_cnt - ur0, 1);
    check("t4_ready", bus.tx_ready, 1);
    read_byte(1'b1, d);
    check("t4_byte", d, 8'hFF);
    check("t4_underrun_once", ur_cnt - ur0, 1);
    stop_cond();
    // repeated START after four data bits
    push(8'h3C);
    ur0 = ur_cnt;
    start_cond();
    send_byte(8'hA1, ack);
    check("t5_addr_ack", ack, 0);
    for (int i = 3; i >= 0; i--) begin
      bit_io(1'b1, s);
      nib[i] = s;
    end
    check("t5_nibble", nib, 4'h3);
    start_cond();
    check("t5_oe_released", bus.sda_oe, 0);
    check("t5_busy_off", bus.busy, 0);
    send_byte(8'hA1, ack);
    check("t5_readdr_ack", ack, 0);
    check("t5_busy_on", bus.busy, 1);
    read_byte(1'b1, d);
    check("t5_byte", d, 8'hFF);
    check("t5_underrun", ur_cnt - ur0, 1);
    stop_cond();
    // asynchronous reset while driving a zero data bit
    push(8'hA5);
    start_cond();
    send_byte(8'hA1, ack);
    check("t6_addr_ack", ack, 0);
    bit_io(1'b1, s);
    check("t6_bit7", s, 1);
    check("t6_oe_driving", bus.sda_oe, 1);
    #3 rstn = 1'b0;
    #1;
    check("t6_async_oe", bus.sda_oe, 0);
    check("t6_async_busy", bus.busy, 0);
    sda_m = 1'b1;
    scl = 1'b1;
    wait_n(3);
    rstn = 1'b1;
    wait_n(4);
    check("t6_ready_after_rst", bus.tx_ready, 1);
    push(8'h5A);
    start_cond();
    send_byte(8'hA1, ack);
    check("t6_post_ack", ack, 0);
    read_byte(1'b1, d);
    check("t6_post_byte", d, 8'h5A);
    stop_cond();
    check("t6_post_busy", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target_tx.md
Name: i2c_target_tx

Overview:
- I2C target (slave) responder that answers single- and multi-byte master read transactions.
- Watches SCL/SDA and detects START, repeated START and STOP.
- Shifts in the 7-bit address plus the R/W bit and ACKs on a read match.
- Serialises bytes taken from a one-entry holding buffer that local logic fills through a valid/ready handshake. Sits on the peripheral side of the bus, opposite the read master.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchroniser depth for scl_in and sda_in (minimum 2).
- UNDERRUN_BYTE, 8'hFF, byte transmitted when the holding buffer is empty at byte start.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- scl_in  in  1  bus SCL level (asynchronous).
- sda_in  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding buffer empty; byte accepted when tx_valid && tx_ready.
- busy  out  1  high from addressed ACK until STOP / START / NACK.
- byte_done  out  1  one-cycle pulse: byte sent, master ACK sampled.
- master_nack  out  1  one-cycle pulse: master NACKed a byte (end of read).
- underrun  out  1  one-cycle pulse: UNDERRUN_BYTE substituted.

Behaviour:
- Reset (asynchronous): sda_oe=0, tx_ready=1, busy=0, all pulses 0, state IDLE, buffer empty, synchronisers cleared to 1.
- Synchronisers and edge detection:
  - scl_in and sda_in pass through SYNC_STAGES flops, then one registered copy for edge detection.
  - scl_rise and scl_fall are single-cycle strobes.
  - START: synced SDA falls while synced SCL is 1.
  - STOP: synced SDA rises while synced SCL is 1.
- Bus timing requirement: SCL high and low phases ≥ SYNC_STAGES+2 clk each.
- Sampling rules:
  - SDA is sampled only on scl_rise.
  - sda_oe changes only in the clk cycle after scl_fall, or on START/STOP.
- States:
  - IDLE: sda_oe=0. START → ADDR with bit counter=0.
  - ADDR: on each scl_rise, shift sda into addr_sr MSB-first and increment the counter. After the 8th rise, wait for scl_fall.
    - If addr_sr[7:1]==DEV_ADDR and addr_sr[0]==1: go to ACK_ADDR and assert sda_oe.
    - Otherwise (mismatch or write): go to WAIT_STOP with sda_oe=0, i.e. NACK.
  - ACK_ADDR: hold sda_oe=1 through the ninth SCL pulse. On the following scl_fall, load the shift register and go to TX.
    - Load source: the buffer if full (buffer becomes empty, tx_ready=1).
    - Otherwise UNDERRUN_BYTE, with an underrun pulse.
    - On that same clk, sda_oe = ~shift[7]. busy=1 from ACK_ADDR entry.
  - TX: each scl_fall after the first shifts left and drives sda_oe = ~shift[7]. After the 8th bit's scl_fall, sda_oe=0 and go to MACK.
  - MACK: on scl_rise, sample sda.
    - sda=0 (ACK): byte_done pulse. At the next scl_fall, load the next byte as in ACK_ADDR and go to TX.
    - sda=1 (NACK): byte_done and master_nack pulse on the same cycle; busy=0; go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; ignore SCL. STOP → IDLE. START → ADDR.
- STOP in any state: IDLE in the next cycle, sda_oe=0, busy=0. The buffer content is preserved.
- START (repeated) in any state: ADDR, sda_oe=0, busy=0.
- Holding buffer:
  - Single entry. tx_ready = ~full.
  - A write accepted in the same cycle as a load fills the buffer after the load (load has priority, then the write is stored).
  - tx_data is ignored when tx_ready=0.
- The block never drives SDA during START/STOP or while SCL is high, except the ACK bit and data bits, which are held stable across the high phase.
- Reset mid-transaction: releases SDA immediately (asynchronous), returns to IDLE, clears the buffer.

Test Plan:
- Buffer preloaded 8'hA5; master reads address 0x50 (byte 8'hA1); master NACKs → ACK low on 9th SCL; bus bits 1,0,1,0,0,1,0,1; byte_done and master_nack pulse once; busy falls; STOP → IDLE.
- Master addresses 0x51 read, then 0x50 write (8'hA0) → sda_oe stays 0 throughout both, including 9th clocks; busy never asserts.
- Two-byte read with buffer refilled (8'h3C, then 8'hC3 written after the first tx_ready) → 0x3C, master ACK, 0xC3, master NACK; two byte_done pulses; one master_nack pulse.
- Empty buffer at address ACK → 8'hFF transmitted; underrun pulses once; tx_ready stays 1.
- Repeated START injected after 4 data bits → sda_oe released within one cycle of START detect; a new address phase to 0x50 read is ACKed normally.
- rstn asserted mid data byte with sda_oe=1 → sda_oe=0 asynchronously; after release, the next START/address completes correctly.
